mem_lane_sequencer: RTL
=======================

// Module: mem_lane_sequencer
// PURPOSE
//  Upstream driver of the 6-bank unified data memory. Accepts one vector load/store request
//  (base, stride, beat count) and issues it one beat per cycle. Each beat sends the same
//  address to all 6 banks, with optional per-lane write gating.
//  Load bytes go back to the pipeline through a registered, back-pressured response port.
//  Store bytes are taken from a streaming write-data port.
// PARAMETERS
//  WIDTH    16  per-lane address / write-data width (matches the memory lane width)
//  LENW     8   width of the beat-count field
//  NLANES   6   lane count (from mem_seq_pkg; fixed to the memory bank count)
// PORTS
//  clk        in   1          clock; every register updates on posedge
//  reset      in   1          synchronous, active-high
//  req_valid  in   1          request valid
//  req_ready  out  1          1 only in IDLE
//  req_op     in   1          0=LOAD 1=STORE (mem_seq_pkg::op_e)
//  req_base   in   WIDTH      first-beat address
//  req_stride in   WIDTH      address increment per beat
//  req_len    in   LENW       beat count; 0 = no-op
//  req_mask   in   6          lane write mask (only with LANE_MASK_EN)
//  st_valid   in   1          store beat data valid
//  st_ready   out  1          store beat accepted
//  st_data    in   48         6 lanes x 8 bits; lane i at [8i+7:8i]
//  rsp_valid  out  1          load beat valid
//  rsp_ready  in   1          consumer accepts the load beat
//  rsp_data   out  48         6 lanes x 8 bits, registered
//  mem_we     out  6          to memory we
//  mem_a      out  WIDTH*6    to memory a; lane i at [WIDTH*(i+1)-1:WIDTH*i]
//  mem_wd     out  WIDTH*6    to memory wd; each lane's byte zero-extended
//  mem_rd     in   48         from memory rd (combinational read)
//  busy       out  1          state != IDLE
//  done       out  1          one-cycle pulse when the request has issued all beats
// BEHAVIOUR
//  Reset: state=IDLE, rsp_valid=0, rsp_data=0, done=0, addr=0, beat=0.
//   Resulting outputs: busy=0, req_ready=1, mem_we=0, mem_a=0, st_ready=0.
//  Reset mid-request aborts the request. mem_we is 0 from the first cycle after reset.
//   Writes already committed stay in memory; a pending response is dropped.
//  FSM IDLE -> RUN -> DONE -> IDLE.
//  IDLE: on req_valid, latch op/base/stride/len/mask; set addr=base, beat=0.
//   len==0 -> DONE, no memory access; else -> RUN.
//  RUN LOAD: a beat issues when !rsp_valid || rsp_ready.
//   On issue: mem_a = addr on all lanes; mem_rd registers into rsp_data; rsp_valid=1 next cycle.
//   Load latency: 1 cycle, address to rsp_valid.
//  RUN STORE: st_ready = 1. A beat issues when st_valid.
//   On issue: mem_we = mask (all ones without LANE_MASK_EN) and mem_wd lane i = {0, st_data byte i}.
//   The memory commits on the same posedge.
//  mem_we is 0 in every cycle where no store beat issues.
//  Every issued beat: addr <= addr + stride, modulo 2^WIDTH (wraps, no flag); beat <= beat + 1.
//   Issuing beat len-1 moves the FSM to DONE.
//  DONE: done=1 for exactly one cycle, then IDLE. req_ready=0 while in DONE.
//  rsp_valid clears on rsp_ready when no new beat issues the same cycle.
//   Simultaneous consume and issue keeps rsp_valid=1 with the new data (full throughput).
//  The last load beat may still be pending after done. The next load issues only once it drains.
//  While rsp_valid && !rsp_ready: rsp_data holds stable and no load beat issues.
//  Full-rate stream: 1 beat/cycle; total latency = len cycles + 1 DONE cycle.
// CONFIGURATION
//  LANE_MASK_EN defined: req_mask is latched and gates mem_we per lane.
//   Lanes with mask 0 are never written. Loads ignore the mask.
//  LANE_MASK_EN undefined: the req_mask port is absent and stores write all 6 lanes.
// STRUCTURE
//  mem_seq_pkg: NLANES=6, op_e {OP_LOAD, OP_STORE}, state_e {IDLE, RUN, DONE}, lane-slice helpers.
//  Sub-module mem_seq_addr_gen: base/stride address register plus beat counter.
//   Inputs: load, step. Outputs: addr, last.
//  The top level holds the FSM, handshakes and response register.
// TESTING
//  1. LOAD base=0 stride=1 len=4, rsp_ready=1 -> mem_a on all lanes 0,1,2,3 on consecutive
//     cycles; rsp_valid for 4 cycles; done 1 cycle after the last issue.
//  2. STORE base=2 len=1 st_data=0xA5 on all lanes -> mem_we=6'h3F for 1 cycle;
//     a LOAD at 2 then returns 0xA5 in every lane.
//  3. LOAD len=3, rsp_ready held 0 for 5 cycles -> one beat issued; rsp_data stable;
//     mem_a held; the rest issue once rsp_ready=1.
//  4. LOAD base=16'hFFFF stride=1 len=2 -> second address 16'h0000.
//     len=0 -> done after 1 cycle, mem_we=0, no rsp.
//  5. Reset asserted mid-STORE, 2nd of 4 beats -> next cycle: mem_we=0, busy=0, req_ready=1;
//     only beat 0 written.
//  6. LANE_MASK_EN, mask=6'b000101, STORE -> only lanes 0 and 2 written; other banks unchanged.

Source files
------------

// File: rtl/mem_seq_pkg.sv
// mem_seq_pkg: shared types and helpers for the memory lane sequencer.
//   NLANES  - number of memory banks / lanes (fixed at 6)
//   BYTEW   - per-lane data byte width
//   op_e    - request operation (load / store)
//   state_e - sequencer FSM states
//   lane_byte() - extracts lane i's byte from a packed NLANES x BYTEW bus
package mem_seq_pkg;

    localparam int unsigned NLANES = 6;
    localparam int unsigned BYTEW  = 8;

    typedef enum logic {
        OP_LOAD  = 1'b0,
        OP_STORE = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic [BYTEW-1:0] lane_byte(input logic [NLANES*BYTEW-1:0] bus,
                                                   input int unsigned lane);
        return bus[lane*BYTEW +: BYTEW];
    endfunction

endpackage

// File: rtl/mem_seq_addr_gen.sv
// mem_seq_addr_gen: beat address generator for the lane sequencer.
//   clk, reset - clock, synchronous active-high reset
//   load_i     - capture base/stride/len, restart at beat 0
//   step_i     - one beat issued: addr += stride (wraps), beat += 1
//   base_i, stride_i, len_i - request fields sampled on load_i
//   addr_o     - address of the current beat
//   last_o     - current beat is the final one (beat == len-1)
module mem_seq_addr_gen #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned LENW  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] base_i,
    input  logic [WIDTH-1:0] stride_i,
    input  logic [LENW-1:0]  len_i,
    output logic [WIDTH-1:0] addr_o,
    output logic             last_o
);

    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] stride_q, stride_d;
    logic [LENW-1:0]  len_q, len_d;
    logic [LENW-1:0]  beat_q, beat_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q   <= '0;
            stride_q <= '0;
            len_q    <= '0;
            beat_q   <= '0;
        end else begin
            addr_q   <= addr_d;
            stride_q <= stride_d;
            len_q    <= len_d;
            beat_q   <= beat_d;
        end
    end

    always_comb begin
        addr_d   = addr_q;
        stride_d = stride_q;
        len_d    = len_q;
        beat_d   = beat_q;
        if (load_i) begin
            addr_d   = base_i;
            stride_d = stride_i;
            len_d    = len_i;
            beat_d   = '0;
        end else if (step_i) begin
            addr_d = addr_q + stride_q;
            beat_d = beat_q + LENW'(1);
        end
    end

    assign addr_o = addr_q;
    assign last_o = (beat_q == len_q - LENW'(1));

endmodule

// File: rtl/mem_lane_sequencer.sv
// mem_lane_sequencer: issues one vector load/store request to the 6-bank data memory,
// one beat per cycle, same address on every lane.
//   clk, reset            - clock, synchronous active-high reset
//   req_*                 - request handshake (op, base, stride, beat count, lane mask)
//   st_valid/ready/data   - streaming store data, 6 lanes x 8 bits
//   rsp_valid/ready/data  - registered, back-pressured load response
//   mem_we/a/wd, mem_rd   - memory bank interface (combinational read)
//   busy, done            - status; done pulses one cycle after the last beat issues
// Build option: LANE_MASK_EN adds the req_mask port, which gates mem_we per lane.
module mem_lane_sequencer
    import mem_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned LENW  = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_op,
    input  logic [WIDTH-1:0]          req_base,
    input  logic [WIDTH-1:0]          req_stride,
    input  logic [LENW-1:0]           req_len,
`ifdef LANE_MASK_EN
    input  logic [NLANES-1:0]         req_mask,
`endif
    input  logic                      st_valid,
    output logic                      st_ready,
    input  logic [NLANES*BYTEW-1:0]   st_data,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [NLANES*BYTEW-1:0]   rsp_data,
    output logic [NLANES-1:0]         mem_we,
    output logic [WIDTH*NLANES-1:0]   mem_a,
    output logic [WIDTH*NLANES-1:0]   mem_wd,
    input  logic [NLANES*BYTEW-1:0]   mem_rd,
    output logic                      busy,
    output logic                      done
);

    state_e                  state_q, state_d;
    op_e                     op_q, op_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [NLANES*BYTEW-1:0] rsp_data_q, rsp_data_d;
    logic [NLANES-1:0]       wr_mask;
    logic                    accept, issue_load, issue_store, issue, last;
    logic [WIDTH-1:0]        addr;

`ifdef LANE_MASK_EN
    logic [NLANES-1:0] mask_q, mask_d;

    always_ff @(posedge clk) begin
        if (reset) mask_q <= '0;
        else       mask_q <= mask_d;
    end

    assign mask_d  = accept ? req_mask : mask_q;
    assign wr_mask = mask_q;
`else
    assign wr_mask = '1;
`endif

    mem_seq_addr_gen #(
        .WIDTH (WIDTH),
        .LENW  (LENW)
    ) u_addr_gen (
        .clk      (clk),
        .reset    (reset),
        .load_i   (accept),
        .step_i   (issue),
        .base_i   (req_base),
        .stride_i (req_stride),
        .len_i    (req_len),
        .addr_o   (addr),
        .last_o   (last)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= OP_LOAD;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        op_d    = accept ? op_e'(req_op) : op_q;
        unique case (state_q)
            IDLE: if (accept) state_d = (req_len == '0) ? DONE : RUN;
            RUN:  if (issue && last) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs and beat issue. Issue is suppressed during reset so an aborted store
    // cannot commit a beat in the reset cycle.
    always_comb begin
        req_ready   = (state_q == IDLE);
        busy        = (state_q != IDLE);
        done        = (state_q == DONE);
        accept      = req_ready && req_valid && !reset;
        st_ready    = (state_q == RUN) && (op_q == OP_STORE) && !reset;
        issue_store = st_ready && st_valid;
        issue_load  = (state_q == RUN) && (op_q == OP_LOAD) && !reset &&
                      (!rsp_valid_q || rsp_ready);
        issue       = issue_store || issue_load;
        mem_we      = issue_store ? wr_mask : '0;
    end

    for (genvar i = 0; i < NLANES; i++) begin : g_lane
        assign mem_a[WIDTH*i +: WIDTH]  = addr;
        assign mem_wd[WIDTH*i +: WIDTH] = {{(WIDTH-BYTEW){1'b0}}, lane_byte(st_data, i)};
    end

    // Response register: a new beat replaces the held one only when the slot is free
    // or being consumed in the same cycle.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        if (issue_load) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = mem_rd;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

endmodule
